aes_run_ctrl: RTL and testbench

AES_RUN_CTRL -- requirements
Module: aes_run_ctrl

---
 rtl/aes_run_ctrl_pkg.sv | 43 ++++
 rtl/aes_run_ctrl_if.sv | 15 +
 rtl/aes_run_csr.sv | 105 ++++++++++
 rtl/aes_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_aes_run_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_run_ctrl_pkg.sv
// Shared definitions for the AES run controller: FSM encoding, register map, bit fields.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package aes_run_ctrl_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  // FSM encoding kept as plain constants so legacy tools and dumps decode the same values
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RESET = 3'd1;
  localparam state_t ST_ARM   = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_GAP   = 3'd4;
  localparam state_t ST_ERROR = 3'd5;

  // Word addresses
  localparam logic [ADDR_W-1:0] A_CTRL       = 3'd0;
  localparam logic [ADDR_W-1:0] A_STATUS     = 3'd1;
  localparam logic [ADDR_W-1:0] A_RUN_TARGET = 3'd2;
  localparam logic [ADDR_W-1:0] A_RUN_COUNT  = 3'd3;
  localparam logic [ADDR_W-1:0] A_RST_CYCLES = 3'd4;
  localparam logic [ADDR_W-1:0] A_LAST_LAT   = 3'd5;

  // CTRL bits
  localparam int CTRL_GO     = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int STS_BUSY      = 0;
  localparam int STS_COMPLETE  = 1;
  localparam int STS_TIMEOUT   = 2;
  localparam int STS_STATE_LSB = 3;

  // Programmed reset length with a floor, so the core always sees a valid reset pulse
  function automatic logic [DATA_W-1:0] rst_floor(input logic [DATA_W-1:0] prog,
                                                  input logic [DATA_W-1:0] min_c);
    return (prog < min_c) ? min_c : prog;
  endfunction

endpackage

// File: rtl/aes_run_ctrl_if.sv
// Avalon-MM slave register bus between host and the AES run controller.
// Latency: writes take effect on the next clk edge; reads are combinational.
// Backpressure: none; the slave never stalls the host.
interface aes_run_ctrl_if;
  import aes_run_ctrl_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/aes_run_csr.sv
// Register file for the AES run controller: Avalon decode, control/status registers, read mux.
// Latency: register writes land on the next clk edge; readdata is combinational.
// Backpressure: none; config writes while busy are silently dropped.
module aes_run_csr
  import aes_run_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  aes_run_ctrl_if.slave     bus,
  input  state_t            state,
  input  logic              clr_run,
  input  logic              done_evt,
  input  logic [DATA_W-1:0] lat_val,
  input  logic              set_complete,
  input  logic              set_timeout,
  output logic              go_req,
  output logic              abort_req,
  output logic              irq_en,
  output logic              complete,
  output logic              timeout_err,
  output logic [DATA_W-1:0] run_target,
  output logic [DATA_W-1:0] rst_cycles,
  output logic [DATA_W-1:0] run_count
);

  logic              wr;
  logic              busy;
  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_target;
  logic              wr_rstc;
  logic [DATA_W-1:0] last_lat;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_ctrl   = wr && (bus.address == A_CTRL);
  assign wr_status = wr && (bus.address == A_STATUS);
  assign wr_target = wr && (bus.address == A_RUN_TARGET);
  assign wr_rstc   = wr && (bus.address == A_RST_CYCLES);
  assign busy      = (state != ST_IDLE);

  // go/abort are pure strobes, never stored
  assign go_req    = wr_ctrl & bus.writedata[CTRL_GO];
  assign abort_req = wr_ctrl & bus.writedata[CTRL_ABORT];

  // Software configuration; run parameters frozen while a sequence is in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en     <= 1'b0;
      run_target <= '0;
      rst_cycles <= '0;
    end else begin
      if (wr_ctrl)           irq_en     <= bus.writedata[CTRL_IRQ_EN];
      if (wr_target && !busy) run_target <= bus.writedata;
      if (wr_rstc && !busy)   rst_cycles <= bus.writedata;
    end
  end

  // Sticky status flags: a new go clears them, hardware set beats a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      complete    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (clr_run)                                       complete <= 1'b0;
      else if (set_complete)                             complete <= 1'b1;
      else if (wr_status && bus.writedata[STS_COMPLETE]) complete <= 1'b0;

      if (clr_run)                                      timeout_err <= 1'b0;
      else if (set_timeout)                             timeout_err <= 1'b1;
      else if (wr_status && bus.writedata[STS_TIMEOUT]) timeout_err <= 1'b0;
    end
  end

  // Run bookkeeping: count saturates rather than wrapping, latency of the latest encryption
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_count <= '0;
      last_lat  <= '0;
    end else begin
      if (clr_run)                        run_count <= '0;
      else if (done_evt && ~&run_count)   run_count <= run_count + 1'b1;
      if (done_evt)                       last_lat  <= lat_val;
    end
  end

  // Read mux; unmapped words and write-only bits read as zero
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      A_CTRL:       bus.readdata[CTRL_IRQ_EN] = irq_en;
      A_STATUS: begin
        bus.readdata[STS_BUSY]               = busy;
        bus.readdata[STS_COMPLETE]           = complete;
        bus.readdata[STS_TIMEOUT]            = timeout_err;
        bus.readdata[STS_STATE_LSB +: 3]     = state;
      end
      A_RUN_TARGET: bus.readdata = run_target;
      A_RUN_COUNT:  bus.readdata = run_count;
      A_RST_CYCLES: bus.readdata = rst_cycles;
      A_LAST_LAT:   bus.readdata = last_lat;
      default:      bus.readdata = '0;
    endcase
  end

endmodule

// File: rtl/aes_run_ctrl.sv
// Sequences repeated AES encryptions: reset core, arm, start+trigger, wait done, repeat to target.
// Latency: aes_start/trig_out 1 cycle after ARM; reset-low window max(RST_CYCLES, MIN_RST_CYCLES).
// Backpressure: none; waits up to TIMEOUT_CYCLES for aes_done, then parks in ERROR until W1C.
module aes_run_ctrl
  import aes_run_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MIN_RST_CYCLES = 2
)
(
  input  logic          clk,
  input  logic          reset_n,
  aes_run_ctrl_if.slave bus,
  output logic          aes_reset_n,
  output logic          aes_start,
  input  logic          aes_done,
  output logic          trig_out,
  output logic          irq
);

  state_t            state;
  state_t            state_nxt;
  logic              go_req;
  logic              abort_req;
  logic              abort_take;
  logic              abort_q;
  logic              irq_en;
  logic              complete;
  logic              timeout_err;
  logic [DATA_W-1:0] run_target;
  logic [DATA_W-1:0] rst_cycles;
  logic [DATA_W-1:0] run_count;
  logic [DATA_W-1:0] rst_len;
  logic [DATA_W-1:0] rst_cnt;
  logic [DATA_W-1:0] lat_cnt;
  logic              clr_run;
  logic              done_evt;
  logic              set_complete;
  logic              set_timeout;
  logic              rst_n_nxt;

  aes_run_csr u_csr (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .state        (state),
    .clr_run      (clr_run),
    .done_evt     (done_evt),
    .lat_val      (lat_cnt),
    .set_complete (set_complete),
    .set_timeout  (set_timeout),
    .go_req       (go_req),
    .abort_req    (abort_req),
    .irq_en       (irq_en),
    .complete     (complete),
    .timeout_err  (timeout_err),
    .run_target   (run_target),
    .rst_cycles   (rst_cycles),
    .run_count    (run_count)
  );

  assign rst_len    = rst_floor(rst_cycles, DATA_W'(MIN_RST_CYCLES));
  assign abort_take = abort_req && (state != ST_IDLE);
  assign irq        = irq_en & (complete | timeout_err);

  // Next-state and event decode; abort overrides every other transition
  always_comb begin
    state_nxt    = state;
    clr_run      = 1'b0;
    done_evt     = 1'b0;
    set_complete = 1'b0;
    set_timeout  = 1'b0;
    if (abort_take) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go_req && !abort_req && (run_target != '0)) begin
            clr_run   = 1'b1;
            state_nxt = ST_RESET;
          end
        end
        ST_RESET: if (rst_cnt >= rst_len) state_nxt = ST_ARM;
        ST_ARM:   state_nxt = ST_RUN;
        ST_RUN: begin
          if (aes_done) begin
            done_evt  = 1'b1;
            state_nxt = ST_GAP;
          end else if (lat_cnt >= DATA_W'(TIMEOUT_CYCLES)) begin
            set_timeout = 1'b1;
            state_nxt   = ST_ERROR;
          end
        end
        ST_GAP: begin
          if (run_count == run_target) begin
            set_complete = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            state_nxt = ST_RESET;
          end
        end
        ST_ERROR: if (!timeout_err) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Core reset level: low in RESET/ERROR and for one cycle on abort; released only by RESET->ARM,
  // and an abort only restores it if the core had already been released
  always_comb begin
    rst_n_nxt = aes_reset_n;
    if (abort_take || state_nxt == ST_RESET || state_nxt == ST_ERROR) rst_n_nxt = 1'b0;
    else if (state == ST_RESET && state_nxt == ST_ARM)                rst_n_nxt = 1'b1;
    else if (abort_q)                                                 rst_n_nxt = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Reset-window counter (1 on first RESET cycle) and latency counter (1 on the aes_start cycle)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt <= '0;
      lat_cnt <= '0;
    end else begin
      if (state_nxt == ST_RESET && state != ST_RESET) rst_cnt <= DATA_W'(1);
      else if (state == ST_RESET)                     rst_cnt <= rst_cnt + 1'b1;
      if (state == ST_ARM)                            lat_cnt <= DATA_W'(1);
      else if (state == ST_RUN)                       lat_cnt <= lat_cnt + 1'b1;
    end
  end

  // Registered core-facing outputs; start and trigger pulse together on the first RUN cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aes_reset_n <= 1'b0;
      aes_start   <= 1'b0;
      trig_out    <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      aes_reset_n <= rst_n_nxt;
      aes_start   <= (state == ST_ARM) && !abort_take;
      trig_out    <= (state == ST_ARM) && !abort_take;
      abort_q     <= abort_take && aes_reset_n;
    end
  end

endmodule

// File: tb/tb_aes_run_ctrl.sv
// Self-checking bench for aes_run_ctrl: directed scenarios plus randomized run sequences.
// Expected values come from a sequence-level model (counts, windows, latencies), not RTL state.
module tb_aes_run_ctrl;

  localparam int TIMEOUT = 1024;
  localparam int MIN_RST = 2;

  localparam logic [2:0] R_CTRL   = 3'd0;
  localparam logic [2:0] R_STATUS = 3'd1;
  localparam logic [2:0] R_TARGET = 3'd2;
  localparam logic [2:0] R_COUNT  = 3'd3;
  localparam logic [2:0] R_RSTC   = 3'd4;
  localparam logic [2:0] R_LAT    = 3'd5;

  logic clk = 1'b0;
  logic reset_n;
  logic aes_reset_n;
  logic aes_start;
  logic aes_done;
  logic trig_out;
  logic irq;

  int tests = 0;
  int fails = 0;

  aes_run_ctrl_if bus ();

  aes_run_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .MIN_RST_CYCLES(MIN_RST)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .aes_reset_n (aes_reset_n),
    .aes_start   (aes_start),
    .aes_done    (aes_done),
    .trig_out    (trig_out),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Observer: start pulses, trigger coincidence, lengths of aes_reset_n low windows
  bit mon_en = 1'b0;
  int starts = 0;
  int trig_bad = 0;
  int low_len = 0;
  int win_n = 0;
  int win [0:15];

  always @(negedge clk) begin
    if (!mon_en) begin
      starts = 0; trig_bad = 0; low_len = 0; win_n = 0;
    end else begin
      if (aes_start === 1'b1) starts++;
      if (trig_out !== aes_start) trig_bad++;
      if (aes_reset_n === 1'b0) low_len++;
      else if (low_len != 0) begin
        if (win_n < 16) win[win_n] = low_len;
        win_n++;
        low_len = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (aes_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // Full run sequence; the model: target pulses, every window max(rcyc, MIN_RST),
  // LAST_LAT = latency of the run just finished, ends IDLE with complete set
  task automatic run_seq(input string tag, input int target, input int rcyc, input int lat [0:7]);
    logic [31:0] rd;
    bit ok;
    int exp_win;
    exp_win = (rcyc < MIN_RST) ? MIN_RST : rcyc;
    bus_wr(R_TARGET, target);
    bus_wr(R_RSTC, rcyc);
    mon_en = 1'b0;
    bus_wr(R_CTRL, 32'h1);
    mon_en = 1'b1;
    for (int r = 0; r < target; r++) begin
      wait_start(ok);
      chk({tag, " start_seen"}, {31'd0, ok}, 32'd1);
      if (!ok) break;
      if (lat[r] > 1) tick(lat[r] - 1);
      aes_done = 1'b1;
      tick(1);
      aes_done = 1'b0;
      bus_rd(R_LAT, rd);
      chk({tag, " last_lat"}, rd, lat[r]);
      bus_rd(R_COUNT, rd);
      chk({tag, " run_count"}, rd, r + 1);
    end
    tick(1);
    bus_rd(R_STATUS, rd);
    chk({tag, " status_done"}, rd, 32'h2);
    chk({tag, " starts"}, starts, target);
    chk({tag, " trig_coincide"}, trig_bad, 0);
    chk({tag, " windows"}, win_n, target);
    for (int w = 0; w < target && w < 16; w++) chk({tag, " window_len"}, win[w], exp_win);
    mon_en = 1'b0;
  endtask

  int lat_a [0:7];
  logic [31:0] rd;
  bit ok;
  int cnt;
  int tgt;
  int rc;

  initial begin
    reset_n        = 1'b0;
    aes_done       = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    for (int i = 0; i < 8; i++) lat_a[i] = 10;

    // Reset state
    tick(3);
    chk("rst_aes_reset_n_in_reset", {31'd0, aes_reset_n}, 32'd0);
    reset_n = 1'b1;
    tick(2);
    chk("rst_aes_reset_n", {31'd0, aes_reset_n}, 32'd0);
    chk("rst_aes_start", {31'd0, aes_start}, 32'd0);
    chk("rst_trig", {31'd0, trig_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), rd);
      chk("rst_reg", rd, 32'd0);
      if (a == 3) tick(1);
    end
    tick(1);

    // Three encryptions, 4-cycle reset windows, done at latency 10
    run_seq("seq3", 3, 4, lat_a);

    // Programmed reset length below the floor
    lat_a[0] = 3;
    run_seq("minrst", 1, 0, lat_a);

    // Same-cycle done, then randomized sequences
    lat_a[0] = 1; lat_a[1] = 2;
    run_seq("lat1", 2, 3, lat_a);
    for (int k = 0; k < 4; k++) begin
      tgt = $urandom_range(1, 4);
      rc  = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) lat_a[i] = $urandom_range(1, 25);
      run_seq("rand", tgt, rc, lat_a);
    end

    // Config writes while busy are dropped; abort returns to idle
    bus_wr(R_TARGET, 2);
    bus_wr(R_RSTC, 3);
    bus_wr(R_CTRL, 32'h1);
    bus_wr(R_TARGET, 7);
    bus_wr(R_RSTC, 9);
    bus_rd(R_TARGET, rd);
    chk("busy_target_hold", rd, 32'd2);
    bus_rd(R_RSTC, rd);
    chk("busy_rstc_hold", rd, 32'd3);
    bus_wr(R_CTRL, 32'h2);
    bus_rd(R_STATUS, rd);
    chk("abort_from_reset", rd, 32'h0);

    // go and abort together in IDLE: abort wins, nothing starts
    bus_wr(R_CTRL, 32'h3);
    tick(1);
    bus_rd(R_STATUS, rd);
    chk("go_abort_same", rd, 32'h0);

    // go with zero target is ignored
    bus_wr(R_TARGET, 0);
    bus_wr(R_CTRL, 32'h1);
    tick(1);
    bus_rd(R_STATUS, rd);
    chk("go_target0_busy", rd, 32'h0);

    // Abort on RUN cycle 5, later done ignored
    bus_wr(R_TARGET, 2);
    bus_wr(R_RSTC, 2);
    bus_wr(R_CTRL, 32'h1);
    wait_start(ok);
    chk("abort_start_seen", {31'd0, ok}, 32'd1);
    tick(4);
    bus_wr(R_CTRL, 32'h2);
    bus_rd(R_STATUS, rd);
    chk("abort_idle", rd, 32'h0);
    chk("abort_rst_low", {31'd0, aes_reset_n}, 32'd0);
    tick(1);
    chk("abort_rst_release", {31'd0, aes_reset_n}, 32'd1);
    aes_done = 1'b1;
    tick(1);
    aes_done = 1'b0;
    tick(1);
    bus_rd(R_COUNT, rd);
    chk("abort_count", rd, 32'd0);
    bus_rd(R_STATUS, rd);
    chk("abort_no_complete", rd, 32'h0);

    // Timeout with no aes_done
    bus_wr(R_TARGET, 1);
    bus_wr(R_CTRL, 32'h5);
    wait_start(ok);
    chk("to_start_seen", {31'd0, ok}, 32'd1);
    cnt = 0;
    rd  = '0;
    while (cnt < 2000) begin
      tick(1);
      cnt++;
      bus_rd(R_STATUS, rd);
      if (rd[5:3] == 3'd5) break;
    end
    chk("to_cycles", cnt, TIMEOUT);
    chk("to_status", rd, 32'h2D);
    chk("to_irq", {31'd0, irq}, 32'd1);
    chk("to_aes_reset_n", {31'd0, aes_reset_n}, 32'd0);
    tick(5);
    bus_rd(R_STATUS, rd);
    chk("to_error_holds", rd, 32'h2D);
    bus_wr(R_STATUS, 32'h4);
    tick(1);
    bus_rd(R_STATUS, rd);
    chk("to_w1c_idle", rd, 32'h0);
    chk("to_irq_clear", {31'd0, irq}, 32'd0);

    // Asynchronous reset in the middle of RUN
    bus_wr(R_CTRL, 32'h5);
    wait_start(ok);
    chk("ar_start_seen", {31'd0, ok}, 32'd1);
    tick(3);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_aes_reset_n", {31'd0, aes_reset_n}, 32'd0);
    chk("ar_aes_start", {31'd0, aes_start}, 32'd0);
    chk("ar_trig", {31'd0, trig_out}, 32'd0);
    chk("ar_irq", {31'd0, irq}, 32'd0);
    bus_rd(R_STATUS, rd);
    chk("ar_status", rd, 32'h0);
    bus_rd(R_CTRL, rd);
    chk("ar_ctrl", rd, 32'h0);
    bus_rd(R_TARGET, rd);
    chk("ar_target", rd, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("ar_held_after", {31'd0, aes_reset_n}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
